// File: rtl/cevero_dvfs_pkg.sv
// cevero_dvfs_pkg
// Shared definitions for the DVFS controller / actuator pair: sequencer
// state encoding and the voltage-code / frequency widths carried on the
// DVFS control interface.
package cevero_dvfs_pkg;

    localparam int VOLT_W = 3;
    localparam int FREQ_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        VUP,
        FUP,
        FDN,
        VDN,
        FONLY,
        DONE
    } dvfs_state_e;

endpackage

// File: rtl/cevero_dvfs_vreg_hs.sv
// cevero_dvfs_vreg_hs
// Request/ack handshake with the voltage regulator, bounded by a timeout.
// Shared by the voltage-up and voltage-down legs of the sequencer.
//   i_clk, i_rst : clock, async active-high reset
//   i_start      : one-cycle strobe, raises the request and clears the timer
//   i_ack        : regulator acknowledge, only looked at while o_req=1
//   o_req        : request to the regulator, held until ack or timeout
//   o_ack_ok     : ack accepted this cycle (request drops on the next edge)
//   o_tmo        : last waiting cycle passed without ack
module cevero_dvfs_vreg_hs #(
    parameter int VregTimeout = 64,
    parameter int CntW        = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_ack_ok,
    output logic o_tmo
);

    logic            r_req;
    logic [CntW-1:0] r_cnt;

    // Ack has priority over expiry when both land on the last cycle.
    assign o_ack_ok = r_req & i_ack;
    assign o_tmo    = r_req & ~i_ack & (r_cnt == CntW'(VregTimeout - 1));
    assign o_req    = r_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_req <= 1'b1;
            r_cnt <= '0;
        end else if (r_req) begin
            if (o_ack_ok || o_tmo) r_req <= 1'b0;
            else                   r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cevero_dvfs_actuator.sv
// cevero_dvfs_actuator
// Applies the DVFS controller's requested operating point in a safe order:
// raising voltage goes voltage -> frequency, lowering goes frequency ->
// voltage, so the clock never runs faster than the applied supply allows.
//   clk_i, rst_i   : clock, async active-high reset
//   req_voltage_i  : requested voltage code (level)
//   req_freq_i     : requested frequency (level)
//   vreg_ack_i     : regulator reached target
//   vdd_sel_o      : voltage code to regulator
//   vreg_req_o     : regulator change request
//   freq_o         : applied frequency
//   freq_upd_o     : one-cycle pulse when freq_o changes
//   busy_o         : sequence in progress
//   done_o         : one-cycle pulse on successful completion
//   timeout_o      : one-cycle pulse on regulator timeout
module cevero_dvfs_actuator
    import cevero_dvfs_pkg::*;
#(
    parameter int MinVoltage   = 0,
    parameter int MaxVoltage   = 5,
    parameter int MinFreq      = 10,
    parameter int MaxFreq      = 100,
    parameter int ResetVoltage = 5,
    parameter int ResetFreq    = 100,
    parameter int VregTimeout  = 64,
    parameter int FreqSettle   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [VOLT_W-1:0] req_voltage_i,
    input  logic [FREQ_W-1:0] req_freq_i,
    input  logic              vreg_ack_i,
    output logic [VOLT_W-1:0] vdd_sel_o,
    output logic              vreg_req_o,
    output logic [FREQ_W-1:0] freq_o,
    output logic              freq_upd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam int CntW = $clog2((VregTimeout > FreqSettle) ? VregTimeout : FreqSettle) + 1;

    dvfs_state_e       r_state, w_next;
    logic [VOLT_W-1:0] r_tv, r_v_applied, r_vdd;
    logic [FREQ_W-1:0] r_tf, r_freq;
    logic              r_upd, r_tmo;
    logic [CntW-1:0]   r_settle;

    logic [VOLT_W-1:0] w_tgt_v, w_new_v;
    logic [FREQ_W-1:0] w_tgt_f, w_new_f;
    logic              w_latch, w_hs_start, w_freq_load, w_revert, w_apply_v;
    logic              w_settle_end, w_ack_ok, w_tmo;

    // Clamp the live request into the legal window (compared wide and signed
    // so a zero lower bound does not degenerate into a constant compare).
    always_comb begin
        w_tgt_v = req_voltage_i;
        if (longint'({{(64-VOLT_W){1'b0}}, req_voltage_i}) < longint'(MinVoltage))
            w_tgt_v = VOLT_W'(MinVoltage);
        else if (longint'({{(64-VOLT_W){1'b0}}, req_voltage_i}) > longint'(MaxVoltage))
            w_tgt_v = VOLT_W'(MaxVoltage);

        w_tgt_f = req_freq_i;
        if (longint'({{(64-FREQ_W){1'b0}}, req_freq_i}) < longint'(MinFreq))
            w_tgt_f = FREQ_W'(MinFreq);
        else if (longint'({{(64-FREQ_W){1'b0}}, req_freq_i}) > longint'(MaxFreq))
            w_tgt_f = FREQ_W'(MaxFreq);
    end

    // Leaving IDLE uses the live target, later legs use the latched copy.
    assign w_new_v      = (r_state == IDLE) ? w_tgt_v : r_tv;
    assign w_new_f      = (r_state == IDLE) ? w_tgt_f : r_tf;
    assign w_settle_end = (r_settle == CntW'(FreqSettle - 1));

    cevero_dvfs_vreg_hs #(
        .VregTimeout (VregTimeout),
        .CntW        (CntW)
    ) u_vreg_hs (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_start  (w_hs_start),
        .i_ack    (vreg_ack_i),
        .o_req    (vreg_req_o),
        .o_ack_ok (w_ack_ok),
        .o_tmo    (w_tmo)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_hs_start  = 1'b0;
        w_freq_load = 1'b0;
        w_revert    = 1'b0;
        w_apply_v   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tgt_v > r_v_applied) begin
                    w_next     = VUP;
                    w_latch    = 1'b1;
                    w_hs_start = 1'b1;
                end else if (w_tgt_v < r_v_applied) begin
                    w_next      = FDN;
                    w_latch     = 1'b1;
                    w_freq_load = 1'b1;
                end else if (w_tgt_f != r_freq) begin
                    w_next      = FONLY;
                    w_latch     = 1'b1;
                    w_freq_load = 1'b1;
                end
            end
            VUP: begin
                if (w_ack_ok) begin
                    w_next      = FUP;
                    w_apply_v   = 1'b1;
                    w_freq_load = 1'b1;
                end else if (w_tmo) begin
                    w_next   = IDLE;
                    w_revert = 1'b1;
                end
            end
            FUP, FONLY: if (w_settle_end) w_next = DONE;
            FDN: begin
                if (w_settle_end) begin
                    w_next     = VDN;
                    w_hs_start = 1'b1;
                end
            end
            VDN: begin
                if (w_ack_ok) begin
                    w_next    = DONE;
                    w_apply_v = 1'b1;
                end else if (w_tmo) begin
                    // Lowered frequency stays in place: it is safe at either voltage.
                    w_next   = IDLE;
                    w_revert = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tv        <= VOLT_W'(ResetVoltage);
            r_tf        <= FREQ_W'(ResetFreq);
            r_v_applied <= VOLT_W'(ResetVoltage);
            r_vdd       <= VOLT_W'(ResetVoltage);
            r_freq      <= FREQ_W'(ResetFreq);
            r_upd       <= 1'b0;
            r_tmo       <= 1'b0;
            r_settle    <= '0;
        end else begin
            r_upd <= 1'b0;
            r_tmo <= 1'b0;
            if (w_latch) begin
                r_tv <= w_tgt_v;
                r_tf <= w_tgt_f;
            end
            if (w_hs_start) r_vdd <= w_new_v;
            if (w_revert) begin
                r_vdd <= r_v_applied;
                r_tmo <= 1'b1;
            end
            if (w_apply_v) r_v_applied <= r_tv;
            // Settle wait runs even when the frequency did not actually move.
            if (w_freq_load) begin
                r_freq   <= w_new_f;
                r_upd    <= (w_new_f != r_freq);
                r_settle <= '0;
            end else if (r_state == FUP || r_state == FDN || r_state == FONLY) begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    assign vdd_sel_o  = r_vdd;
    assign freq_o     = r_freq;
    assign freq_upd_o = r_upd;
    assign timeout_o  = r_tmo;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_cevero_dvfs_actuator.sv
// Bench for cevero_dvfs_actuator: vector table, hand-written corner
// sequences and randomized transactions against an operating-point model.
module tb_cevero_dvfs_actuator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  req_voltage_i;
    logic [31:0] req_freq_i;
    logic        vreg_ack_i;
    logic [2:0]  vdd_sel_o;
    logic        vreg_req_o;
    logic [31:0] freq_o;
    logic        freq_upd_o, busy_o, done_o, timeout_o;

    cevero_dvfs_actuator dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_voltage_i (req_voltage_i),
        .req_freq_i    (req_freq_i),
        .vreg_ack_i    (vreg_ack_i),
        .vdd_sel_o     (vdd_sel_o),
        .vreg_req_o    (vreg_req_o),
        .freq_o        (freq_o),
        .freq_upd_o    (freq_upd_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int mv, mf;   // model: applied voltage code and frequency

    typedef struct {
        int rv; int rf; int lat;
        int ev; int ef; int eo;   // eo: 0 nothing, 1 done, 2 timeout
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // One request/response transaction. lat = cycles after vreg_req_o rises
    // before ack is driven; lat >= 64 means the regulator never answers.
    task automatic run_txn(input int rv, input int rf, input int lat,
                           output int ov, output int of, output int oc);
        int tv, tf, kind, ok, pulses, nv, nf, eo;
        int start, rise, ackc, updc, updv, upd_n, fin, k, badv;
        tv = clampi(rv, 0, 5);
        tf = clampi(rf, 10, 100);
        ok = (lat < 64);
        if (tv > mv) begin
            kind = 1; pulses = (ok && tf != mf); eo = ok ? 1 : 2;
            nv = ok ? tv : mv; nf = ok ? tf : mf;
        end else if (tv < mv) begin
            kind = 2; pulses = (tf != mf); eo = ok ? 1 : 2;
            nv = ok ? tv : mv; nf = tf;
        end else if (tf != mf) begin
            kind = 3; pulses = 1; eo = 1; nv = mv; nf = tf;
        end else begin
            kind = 0; pulses = 0; eo = 0; nv = mv; nf = mf;
        end

        @(negedge clk_i);
        req_voltage_i = 3'(rv);
        req_freq_i    = 32'(rf);
        start = -1; rise = -1; ackc = -1; updc = -1; updv = -1;
        upd_n = 0; fin = -1; k = 0; badv = 0; oc = 0;
        for (int n = 0; n < 300 && oc == 0 && !(kind == 0 && n >= 20); n++) begin
            @(negedge clk_i);
            vreg_ack_i = 1'b0;
            if (busy_o && start < 0) start = cyc;
            if (freq_upd_o) begin upd_n++; updc = cyc; updv = int'(freq_o); end
            if (vreg_req_o) begin
                if (rise < 0) begin rise = cyc; k = 0; end
                else k++;
                if (int'(vdd_sel_o) != tv) badv = 1;
                if (k == lat) begin vreg_ack_i = 1'b1; ackc = cyc; end
            end else begin
                vreg_ack_i = 1'($urandom_range(0, 1));   // must be ignored
            end
            if (done_o)    begin oc = 1; fin = cyc; end
            if (timeout_o) begin oc = 2; fin = cyc; end
        end
        // Park the request on the new operating point so no retry starts.
        vreg_ack_i    = 1'b0;
        req_voltage_i = 3'(nv);
        req_freq_i    = 32'(nf);

        chk("outcome", oc, eo);
        chk("upd_count", upd_n, pulses);
        if (pulses != 0) chk("upd_value", updv, tf);
        chk("vdd_during_req", badv, 0);
        case (kind)
            1: begin
                chk("up_req_first", rise - start, 0);
                if (ok) begin
                    if (pulses != 0) chk("up_freq_after_ack", updc - ackc, 1);
                    chk("up_done_lat", fin - ackc, 9);
                end else chk("up_tmo_lat", fin - rise, 64);
            end
            2: begin
                chk("dn_req_after_settle", rise - start, 8);
                if (pulses != 0) chk("dn_freq_first", updc - start, 0);
                if (ok) chk("dn_done_lat", fin - ackc, 1);
                else    chk("dn_tmo_lat", fin - rise, 64);
            end
            3: begin
                chk("fo_done_lat", fin - start, 8);
                chk("fo_no_vreq", rise, -1);
            end
            default: chk("idle_no_busy", start, -1);
        endcase

        @(negedge clk_i);
        ov = int'(vdd_sel_o);
        of = int'(freq_o);
        chk("end_vdd", ov, nv);
        chk("end_freq", of, nf);
        chk("end_idle", busy_o, 0);
        mv = nv;
        mf = nf;
    endtask

    initial begin
        int ov, of, oc, got, rv, rf, lat;

        tbl[0]  = '{5, 100,  0, 5, 100, 0};
        tbl[1]  = '{3,  50,  2, 3,  50, 1};
        tbl[2]  = '{4,  70,  5, 4,  70, 1};
        tbl[3]  = '{2,  30,  3, 2,  30, 1};
        tbl[4]  = '{3,  50, 99, 2,  30, 2};
        tbl[5]  = '{7, 200,  1, 5, 100, 1};
        tbl[6]  = '{2,   0,  4, 2,  10, 1};
        tbl[7]  = '{2,  10,  0, 2,  10, 0};
        tbl[8]  = '{2,  60,  0, 2,  60, 1};
        tbl[9]  = '{1,  60, 99, 2,  60, 2};
        tbl[10] = '{1,  60, 63, 1,  60, 1};
        tbl[11] = '{0,   5,  0, 0,  10, 1};
        tbl[12] = '{3,  10, 63, 3,  10, 1};

        rst_i = 1'b1;
        req_voltage_i = 3'd5;
        req_freq_i    = 32'd100;
        vreg_ack_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_vdd", vdd_sel_o, 5);
        chk("rst_freq", freq_o, 100);
        chk("rst_req", vreg_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_flags", {freq_upd_o, done_o, timeout_o}, 0);
        mv = 5; mf = 100;

        foreach (tbl[i]) begin
            run_txn(tbl[i].rv, tbl[i].rf, tbl[i].lat, ov, of, oc);
            chk($sformatf("tbl%0d_v", i), ov, tbl[i].ev);
            chk($sformatf("tbl%0d_f", i), of, tbl[i].ef);
            chk($sformatf("tbl%0d_o", i), oc, tbl[i].eo);
        end

        // Timeout on the way up, then the natural retry from IDLE.
        run_txn(3, 50, 1, ov, of, oc);
        @(negedge clk_i);
        req_voltage_i = 3'd4; req_freq_i = 32'd70;
        got = 0;
        for (int n = 0; n < 100 && got == 0; n++) begin
            @(negedge clk_i);
            if (timeout_o) got = 1;
        end
        chk("a_timeout_seen", got, 1);
        chk("a_vdd_revert", vdd_sel_o, 3);
        chk("a_freq_kept", freq_o, 50);
        @(negedge clk_i);
        chk("a_retry_req", vreg_req_o, 1);
        chk("a_retry_vdd", vdd_sel_o, 4);
        vreg_ack_i = 1'b1;
        @(negedge clk_i);
        vreg_ack_i = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk_i);
            if (done_o) got = 1;
        end
        chk("a_done", got, 1);
        chk("a_freq", freq_o, 70);
        mv = 4; mf = 70;

        // Request change during VUP is ignored until IDLE, then reset mid-FDN.
        @(negedge clk_i);
        req_voltage_i = 3'd5; req_freq_i = 32'd90;
        got = 0;
        for (int n = 0; n < 10 && got == 0; n++) begin
            @(negedge clk_i);
            if (vreg_req_o) got = 1;
        end
        chk("b_vup_started", got, 1);
        req_voltage_i = 3'd1; req_freq_i = 32'd20;
        @(negedge clk_i);
        chk("b_vdd_held", vdd_sel_o, 5);
        vreg_ack_i = 1'b1;
        @(negedge clk_i);
        vreg_ack_i = 1'b0;
        chk("b_req_dropped", vreg_req_o, 0);
        chk("b_upd", freq_upd_o, 1);
        chk("b_freq_latched", freq_o, 90);
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk_i);
            if (done_o) got = 1;
        end
        chk("b_done", got, 1);
        chk("b_vdd_final", vdd_sel_o, 5);
        @(negedge clk_i);
        chk("b_idle", busy_o, 0);
        @(negedge clk_i);
        chk("b_reeval_busy", busy_o, 1);
        chk("b_fdn_freq", freq_o, 20);
        chk("b_fdn_noreq", vreg_req_o, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("b_rst_freq", freq_o, 100);
        chk("b_rst_vdd", vdd_sel_o, 5);
        chk("b_rst_busy", busy_o, 0);
        chk("b_rst_upd", freq_upd_o, 0);
        req_voltage_i = 3'd5; req_freq_i = 32'd100;
        @(negedge clk_i);
        rst_i = 1'b0;
        mv = 5; mf = 100;

        // Reset while the regulator request is outstanding.
        run_txn(2, 30, 3, ov, of, oc);
        @(negedge clk_i);
        req_voltage_i = 3'd4; req_freq_i = 32'd70;
        got = 0;
        for (int n = 0; n < 10 && got == 0; n++) begin
            @(negedge clk_i);
            if (vreg_req_o) got = 1;
        end
        chk("c_vup_started", got, 1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("c_rst_req", vreg_req_o, 0);
        chk("c_rst_vdd", vdd_sel_o, 5);
        chk("c_rst_freq", freq_o, 100);
        req_voltage_i = 3'd5; req_freq_i = 32'd100;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("c_idle", busy_o, 0);
        mv = 5; mf = 100;

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            rv = int'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rf = int'($urandom_range(0, 9));
                1:       rf = int'($urandom_range(101, 300));
                default: rf = int'($urandom_range(10, 100));
            endcase
            lat = ($urandom_range(0, 5) == 0) ? 100 : int'($urandom_range(0, 63));
            run_txn(rv, rf, lat, ov, of, oc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
